uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter between NUM_REQ byte-stream requesters, e.g. the message ROM streamer, a debug echo path and a status reporter.
- Grants whole packets, delimited by a per-requester `last` flag.
- Arbitration is round-robin: requesters cannot interleave bytes, and none can starve.
- Sits between the requesters and the tx module's data/request/clear-to-send interface. Keeps packet statistics.

---
 rtl/uart_tx_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
//-----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares a single UART transmitter between NUM_REQ byte-stream requesters.
// Ownership is granted for a whole packet (ended by the requester's `last`
// flag, or forcibly after MAX_LEN bytes). Owners are picked round-robin,
// starting the search one past the previous owner, so no requester starves
// and bytes from different requesters never interleave.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   i_req_valid  per-requester byte valid
//   i_req_data   per-requester byte, requester k on bits [8k+7:8k]
//   i_req_last   per-requester end-of-packet marker
//   o_req_ready  per-requester byte accepted this cycle (owner only)
//   o_tx_data    byte to the transmitter (0 when o_tx_req is low)
//   o_tx_req     transmitter request
//   i_tx_cts     transmitter can take a byte this cycle
//   i_tx_idle    transmitter shift register empty, line idle
//   o_grant      one-hot current owner, zero when no packet is in flight
//   o_busy       high while sending or waiting for the line to go idle
//   o_pkt_count  completed packets, wraps at 0xFFFF
//   o_trunc      sticky flag, a packet was cut at MAX_LEN without `last`
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_LEN   = 64,
    parameter bit WAIT_IDLE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    input  logic [8*NUM_REQ-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]   i_req_last,
    output logic [NUM_REQ-1:0]   o_req_ready,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_req,
    input  logic                 i_tx_cts,
    input  logic                 i_tx_idle,
    output logic [NUM_REQ-1:0]   o_grant,
    output logic                 o_busy,
    output logic [15:0]          o_pkt_count,
    output logic                 o_trunc
);

    localparam int          IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [15:0] LEN_LIMIT = 16'(MAX_LEN);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic [IDX_W-1:0]     r_ptr;
    logic [IDX_W-1:0]     r_owner;
    logic [NUM_REQ-1:0]   r_grant;
    logic [15:0]          r_byteCnt;
    logic [15:0]          r_pktCount;
    logic                 r_trunc;

    logic [IDX_W-1:0]     w_winner;
    logic                 w_found;
    logic                 w_ownerValid;
    logic                 w_ownerLast;
    logic [7:0]           w_ownerData;
    logic                 w_xfer;
    logic                 w_lenHit;
    logic                 w_pktEnd;
    logic [IDX_W-1:0]     w_ptrNext;

    // Owner's lane of the requester buses. r_owner is only meaningful in
    // SEND; every consumer below qualifies it with the state.
    assign w_ownerValid = i_req_valid[r_owner];
    assign w_ownerLast  = i_req_last[r_owner];
    assign w_ownerData  = i_req_data[{r_owner, 3'b000} +: 8];

    // A byte moves when the owner offers one and the transmitter takes it.
    // The packet ends on `last`, or when this byte is the MAX_LEN-th one.
    assign w_xfer    = (r_state == ST_SEND) && w_ownerValid && i_tx_cts;
    assign w_lenHit  = (r_byteCnt == (LEN_LIMIT - 16'd1));
    assign w_pktEnd  = w_xfer && (w_ownerLast || w_lenHit);
    assign w_ptrNext = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

    // Round-robin search: first valid requester at or above the pointer,
    // otherwise the first valid one below it. Two ascending passes give the
    // wrap-around order without a modulo.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && (j >= int'(r_ptr)) && i_req_valid[j]) begin
                w_found  = 1'b1;
                w_winner = IDX_W'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && (j < int'(r_ptr)) && i_req_valid[j]) begin
                w_found  = 1'b1;
                w_winner = IDX_W'(j);
            end
        end
    end

    // State register. Reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and transmitter-side outputs. In SEND the owner's byte is
    // passed straight through and only the owner sees cts as its ready, so
    // everyone else holds their data. GAP lets the line drain before the
    // next packet is arbitrated.
    always_comb begin
        w_nextState = r_state;
        o_tx_req    = 1'b0;
        o_tx_data   = 8'h00;
        o_req_ready = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_nextState = ST_SEND;
                end
            end
            ST_SEND: begin
                o_tx_req             = w_ownerValid;
                o_tx_data            = w_ownerValid ? w_ownerData : 8'h00;
                o_req_ready[r_owner] = i_tx_cts;
                if (w_pktEnd) begin
                    w_nextState = WAIT_IDLE ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (i_tx_idle) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Grant, pointer, byte counter and statistics. The grant is loaded on
    // the arbitration cycle and cleared on the byte that ends the packet,
    // so it is only ever nonzero in SEND. A packet cut at MAX_LEN leaves the
    // requester's remaining bytes to compete as a fresh packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= '0;
            r_owner    <= '0;
            r_grant    <= '0;
            r_byteCnt  <= '0;
            r_pktCount <= '0;
            r_trunc    <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && w_found) begin
                r_owner <= w_winner;
                r_grant <= NUM_REQ'(1) << w_winner;
            end
            if (w_xfer) begin
                if (w_pktEnd) begin
                    r_byteCnt  <= '0;
                    r_pktCount <= r_pktCount + 16'd1;
                    r_ptr      <= w_ptrNext;
                    r_grant    <= '0;
                    if (!w_ownerLast) begin
                        r_trunc <= 1'b1;
                    end
                end else begin
                    r_byteCnt <= r_byteCnt + 16'd1;
                end
            end
        end
    end

    assign o_grant     = r_grant;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_pkt_count = r_pktCount;
    assign o_trunc     = r_trunc;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
//-----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Requesters are modelled as byte queues. Every packet handed to a requester
// is also pushed into that requester's expected queue. A monitor runs a
// packet-level round-robin model and, every cycle, predicts the owner,
// grant, ready, tx request/data and statistics, popping the expected queue
// whenever a byte is seen to move to the transmitter.
//
// Per-cycle ordering after each falling edge:
//   +0 driver pops accepted bytes, drives new inputs
//   +1 driver records handshakes
//   +2 stimulus acts (pushes packets, reset, queue flush)
//   +3 monitor compares and advances the model
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

    localparam int N    = 4;
    localparam int MAXL = 4;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } byteT;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   i_req_valid = '0;
    logic [8*N-1:0] i_req_data = '0;
    logic [N-1:0]   i_req_last = '0;
    logic [N-1:0]   o_req_ready;
    logic [7:0]     o_tx_data;
    logic           o_tx_req;
    logic           i_tx_cts = 1'b1;
    logic           i_tx_idle = 1'b1;
    logic [N-1:0]   o_grant;
    logic           o_busy;
    logic [15:0]    o_pkt_count;
    logic           o_trunc;

    int checks = 0;
    int errors = 0;

    byteT srcQ [N][$];
    byteT expQ [N][$];
    logic [N-1:0] popMask = '0;

    int       ctsMode   = 0;
    int       idleMode  = 0;
    bit       randValid = 1'b0;
    int       stallReq  = -1;
    int       stallAt   = 0;
    int       stallLeft = 0;
    logic [3:0] ctsPat  = 4'b1001;
    int       ctsPh     = 0;
    bit       monOn     = 1'b0;
    logic     vb;

    // Reference model state
    int          mOwner = -1;
    int          mPtr   = 0;
    int          mCnt   = 0;
    bit          mGap   = 1'b0;
    logic [15:0] mPkt   = '0;
    logic        mTrunc = 1'b0;

    logic [N-1:0] eGrant;
    logic [N-1:0] eReady;
    logic         eReq;
    logic [7:0]   eData;
    logic         eBusy;
    byteT         eByte;

    uart_tx_arbiter #(
        .NUM_REQ   (N),
        .MAX_LEN   (MAXL),
        .WAIT_IDLE (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (i_req_valid),
        .i_req_data  (i_req_data),
        .i_req_last  (i_req_last),
        .o_req_ready (o_req_ready),
        .o_tx_data   (o_tx_data),
        .o_tx_req    (o_tx_req),
        .i_tx_cts    (i_tx_cts),
        .i_tx_idle   (i_tx_idle),
        .o_grant     (o_grant),
        .o_busy      (o_busy),
        .o_pkt_count (o_pkt_count),
        .o_trunc     (o_trunc)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pushByte(input int k, input logic [7:0] d, input logic l);
        byteT b;
        b.data = d;
        b.last = l;
        srcQ[k].push_back(b);
        expQ[k].push_back(b);
    endtask

    task automatic applyStimulus(input int k, input int len, input bit useRand, input logic [7:0] base);
        for (int i = 0; i < len; i++) begin
            pushByte(k, useRand ? 8'($urandom) : base + 8'(i), (i == len - 1));
        end
    endtask

    function automatic bit allEmpty();
        for (int k = 0; k < N; k++) begin
            if (srcQ[k].size() != 0 || expQ[k].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic nextSlot();
        @(negedge clk);
        #2;
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n;
        n = 0;
        while (n < budget && !(allEmpty() && mOwner < 0 && !mGap)) begin
            nextSlot();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("[TB] FAIL %s drain timeout actual=%0d cycles required<%0d", name, n, budget);
        end
        repeat (2) nextSlot();
    endtask

    // Requester and transmitter driver
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (popMask[k] && srcQ[k].size() > 0) void'(srcQ[k].pop_front());
        end
        popMask = '0;
        for (int k = 0; k < N; k++) begin
            vb = !rst && (srcQ[k].size() > 0);
            if (randValid && $urandom_range(3) == 0) vb = 1'b0;
            if (vb && k == stallReq && srcQ[k].size() == stallAt && stallLeft > 0) begin
                vb = 1'b0;
                stallLeft--;
            end
            i_req_valid[k]        = vb;
            i_req_data[8*k +: 8]  = vb ? srcQ[k][0].data : 8'($urandom);
            i_req_last[k]         = vb ? srcQ[k][0].last : 1'($urandom);
        end
        case (ctsMode)
            0:       i_tx_cts = 1'b1;
            1:       i_tx_cts = ($urandom_range(2) != 0);
            default: begin
                i_tx_cts = ctsPat[ctsPh[1:0]];
                ctsPh++;
            end
        endcase
        i_tx_idle = (idleMode == 0) ? 1'b1 : ($urandom_range(1) == 1);
        #1;
        popMask = o_req_ready & i_req_valid;
    end

    // Monitor / scoreboard with packet-level round-robin model
    always @(negedge clk) begin
        #3;
        if (monOn) begin
            eGrant = (mOwner >= 0) ? (N'(1) << mOwner) : '0;
            eReady = (mOwner >= 0 && i_tx_cts) ? (N'(1) << mOwner) : '0;
            eReq   = (mOwner >= 0) && i_req_valid[mOwner];
            eBusy  = (mOwner >= 0) || mGap;
            eData  = 8'h00;
            if (eReq) begin
                if (expQ[mOwner].size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL scoreboard_empty owner=%0d actual=0x%0h required=none", mOwner, o_tx_data);
                end else begin
                    eData = expQ[mOwner][0].data;
                end
            end
            checkOutput("grant",     32'(o_grant),     32'(eGrant));
            checkOutput("req_ready", 32'(o_req_ready), 32'(eReady));
            checkOutput("tx_req",    32'(o_tx_req),    32'(eReq));
            checkOutput("tx_data",   32'(o_tx_data),   32'(eData));
            checkOutput("busy",      32'(o_busy),      32'(eBusy));
            checkOutput("pkt_count", 32'(o_pkt_count), 32'(mPkt));
            checkOutput("trunc",     32'(o_trunc),     32'(mTrunc));

            if (rst) begin
                mOwner = -1;
                mPtr   = 0;
                mCnt   = 0;
                mGap   = 1'b0;
                mPkt   = '0;
                mTrunc = 1'b0;
            end else if (mOwner >= 0) begin
                if (eReq && i_tx_cts && expQ[mOwner].size() > 0) begin
                    eByte = expQ[mOwner].pop_front();
                    mCnt++;
                    if (eByte.last || mCnt == MAXL) begin
                        mPkt++;
                        if (!eByte.last) mTrunc = 1'b1;
                        mPtr   = (mOwner + 1) % N;
                        mOwner = -1;
                        mCnt   = 0;
                        mGap   = 1'b1;
                    end
                end
            end else if (mGap) begin
                if (i_tx_idle) mGap = 1'b0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (mOwner < 0 && i_req_valid[(mPtr + i) % N]) mOwner = (mPtr + i) % N;
                end
            end
        end
    end

    // Stimulus sequence
    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        monOn = 1'b1;
        nextSlot();
        rst = 1'b0;
        nextSlot();

        // Single packet "Hi" from requester 0, arbitration costs one cycle
        idleMode = 1;
        pushByte(0, 8'h48, 1'b0);
        pushByte(0, 8'h69, 1'b1);
        nextSlot();
        checkOutput("grant_before_arb", 32'(o_grant), 32'h0);
        nextSlot();
        checkOutput("grant_single", 32'(o_grant), 32'h1);
        waitDrain("single", 200);
        checkOutput("pkt_after_single", 32'(o_pkt_count), 32'd1);
        checkOutput("busy_after_single", 32'(o_busy), 32'd0);

        // Round-robin: all four stream two 3-byte packets
        idleMode = 0;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < N; k++) applyStimulus(k, 3, 1'b0, 8'(16 * k + 4 * r));
        end
        waitDrain("round_robin", 500);
        checkOutput("pkt_after_rr", 32'(o_pkt_count), 32'd9);

        // No interleave: requester 2 stalls 20 cycles mid-packet, 1 waits
        stallReq  = 2;
        stallAt   = 2;
        stallLeft = 20;
        applyStimulus(2, 4, 1'b0, 8'hA0);
        repeat (2) nextSlot();
        applyStimulus(1, 2, 1'b0, 8'hB0);
        repeat (6) nextSlot();
        checkOutput("stall_grant", 32'(o_grant), 32'h4);
        checkOutput("stall_ready1", 32'(o_req_ready[1]), 32'd0);
        waitDrain("interleave", 500);
        stallReq = -1;
        checkOutput("pkt_after_stall", 32'(o_pkt_count), 32'd11);

        // Truncation: 6 bytes with MAX_LEN of 4 becomes two packets
        checkOutput("trunc_before", 32'(o_trunc), 32'd0);
        applyStimulus(1, 6, 1'b0, 8'hC0);
        waitDrain("truncation", 500);
        checkOutput("trunc_after", 32'(o_trunc), 32'd1);
        checkOutput("pkt_after_trunc", 32'(o_pkt_count), 32'd13);

        // Backpressure with cts pattern 1,0,0,1
        ctsMode = 2;
        ctsPh   = 0;
        applyStimulus(3, 5, 1'b0, 8'hD0);
        waitDrain("backpressure", 500);
        ctsMode = 0;
        checkOutput("pkt_after_bp", 32'(o_pkt_count), 32'd15);

        // Reset in the middle of a 4-byte packet
        applyStimulus(3, 4, 1'b0, 8'hE0);
        begin
            int n;
            n = 0;
            while (n < 100 && srcQ[3].size() != 3) begin
                nextSlot();
                n++;
            end
            checks++;
            if (n >= 100) begin
                errors++;
                $display("[TB] FAIL mid_packet_wait timeout actual=%0d required<100", n);
            end
        end
        rst = 1'b1;
        nextSlot();
        for (int k = 0; k < N; k++) begin
            srcQ[k].delete();
            expQ[k].delete();
        end
        popMask = '0;
        checkOutput("rst_grant", 32'(o_grant), 32'h0);
        checkOutput("rst_tx_req", 32'(o_tx_req), 32'd0);
        checkOutput("rst_pkt", 32'(o_pkt_count), 32'd0);
        checkOutput("rst_trunc", 32'(o_trunc), 32'd0);
        nextSlot();
        rst = 1'b0;
        nextSlot();
        applyStimulus(1, 2, 1'b0, 8'h11);
        applyStimulus(2, 2, 1'b0, 8'h22);
        repeat (2) nextSlot();
        checkOutput("ptr_zero_after_rst", 32'(o_grant), 32'h2);
        waitDrain("after_reset", 300);
        checkOutput("pkt_after_reset", 32'(o_pkt_count), 32'd2);

        // Randomized traffic
        randValid = 1'b1;
        ctsMode   = 1;
        idleMode  = 1;
        for (int i = 0; i < 80; i++) begin
            applyStimulus(int'($urandom_range(N - 1)), int'($urandom_range(6, 1)), 1'b1, 8'h00);
            repeat ($urandom_range(4)) nextSlot();
        end
        waitDrain("random", 8000);
        randValid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
